ram_port_arbiter: RTL and testbench

//  Shares the single 4KB byte-lane RAM between the instruction-fetch requester and the load/store requester.
//  The RAM reads combinationally and writes whenever its write enable is high.

---
 rtl/ram_port_arbiter.sv | 111 +++++++++++
 tb/tb_ram_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - fetch vs load/store arbiter for the shared 4KB RAM
module ram_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ready,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        ram_we,
    output logic [3:0]  ram_wsel,
    output logic [31:0] ram_waddr,
    output logic [31:0] ram_wdata,
    output logic [31:0] ram_raddr,
    input  logic [31:0] ram_rdata
);

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic        w_gnt_data;
    logic        w_gnt_inst;
    logic        w_load;
    logic        w_store;
    logic [3:0]  r_starve_cnt;
    logic        r_inst_rvalid;
    logic [31:0] r_inst_rdata;
    logic        r_data_rvalid;
    logic [31:0] r_data_rdata;
    logic        r_ram_we;
    logic [3:0]  r_ram_wsel;
    logic [31:0] r_ram_waddr;
    logic [31:0] r_ram_wdata;

    // One grant per cycle: data wins unless fetch has waited STARVE_MAX data grants; no grants in reset.
    always_comb begin
        w_gnt_data = aresetn & data_req & (~inst_req | (r_starve_cnt < LP_STARVE_MAX));
        w_gnt_inst = aresetn & inst_req & ~w_gnt_data;
        w_load     = w_gnt_data & ~data_wr;
        w_store    = w_gnt_data & data_wr & (|data_wstrb);
        ram_raddr  = w_gnt_data ? data_addr : inst_addr;
    end

    assign inst_ready  = w_gnt_inst;
    assign data_ready  = w_gnt_data;
    assign inst_rvalid = r_inst_rvalid;
    assign inst_rdata  = r_inst_rdata;
    assign data_rvalid = r_data_rvalid;
    assign data_rdata  = r_data_rdata;
    assign ram_we      = r_ram_we;
    assign ram_wsel    = r_ram_wsel;
    assign ram_waddr   = r_ram_waddr;
    assign ram_wdata   = r_ram_wdata;

    // Count data grants taken while fetch is waiting; the grant rule caps it at STARVE_MAX.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_starve_cnt <= 4'd0;
        end else if (w_gnt_data && inst_req) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end

    // Capture the combinational RAM word at the grant edge; rdata holds between pulses.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_inst_rvalid <= 1'b0;
            r_inst_rdata  <= 32'd0;
            r_data_rvalid <= 1'b0;
            r_data_rdata  <= 32'd0;
        end else begin
            r_inst_rvalid <= w_gnt_inst;
            r_data_rvalid <= w_load;
            if (w_gnt_inst) begin
                r_inst_rdata <= ram_rdata;
            end
            if (w_load) begin
                r_data_rdata <= ram_rdata;
            end
        end
    end

    // Register store commands so the RAM sees a clean one-cycle write enable.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_ram_we    <= 1'b0;
            r_ram_wsel  <= 4'd0;
            r_ram_waddr <= 32'd0;
            r_ram_wdata <= 32'd0;
        end else begin
            r_ram_we <= w_store;
            if (w_store) begin
                r_ram_wsel  <= data_wstrb;
                r_ram_waddr <= data_addr;
                r_ram_wdata <= data_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic        inst_ready, inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [3:0]  data_wstrb = 4'd0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic        data_ready, data_rvalid;
    logic [31:0] data_rdata;
    logic        ram_we;
    logic [3:0]  ram_wsel;
    logic [31:0] ram_waddr, ram_wdata, ram_raddr, ram_rdata;

    always #5 aclk = ~aclk;

    ram_port_arbiter #(.STARVE_MAX(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_ready(data_ready),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .ram_we(ram_we), .ram_wsel(ram_wsel), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 0;

    logic [31:0] mem [1024];
    logic [31:0] gold [1024];

    int          m_starve = 0;
    bit          exp_irv = 0, exp_drv = 0, exp_we = 0, m_gi = 0, m_gd = 0;
    logic [3:0]  exp_wsel = 4'd0;
    logic [31:0] exp_waddr = 32'd0, exp_wdata = 32'd0, last_i = 32'd0, last_d = 32'd0;
    logic [31:0] iq [$];
    logic [31:0] dq [$];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] pre_word(input int i);
        if (i == 8) return 32'h11223344;
        return (32'h9E3779B9 * 32'(i + 1)) ^ 32'(i);
    endfunction

    // RAM model: combinational read with the active write merged in, commit on the edge
    always_comb begin
        ram_rdata = mem[ram_raddr[11:2]];
        if (ram_we === 1'b1 && ram_waddr[11:2] == ram_raddr[11:2])
            ram_rdata = merge(mem[ram_raddr[11:2]], ram_wdata, ram_wsel);
    end

    always @(posedge aclk) begin
        if (ram_we === 1'b1) mem[ram_waddr[11:2]] <= merge(mem[ram_waddr[11:2]], ram_wdata, ram_wsel);
    end

    task automatic mon_pos();
        logic gd, gi;
        forever begin
            @(posedge aclk);
            if (mon_en) begin
                if (aresetn !== 1'b1) begin
                    m_starve = 0; exp_irv = 0; exp_drv = 0; exp_we = 0;
                    m_gi = 0; m_gd = 0; last_i = 32'd0; last_d = 32'd0;
                    iq.delete(); dq.delete();
                end else begin
                    gd = data_req & (!inst_req | (m_starve < 4));
                    gi = inst_req & !gd;
                    exp_irv = gi;
                    if (gi) iq.push_back(gold[inst_addr[11:2]]);
                    exp_drv = gd & !data_wr;
                    if (exp_drv) dq.push_back(gold[data_addr[11:2]]);
                    exp_we = gd & data_wr & (|data_wstrb);
                    if (exp_we) begin
                        exp_wsel = data_wstrb; exp_waddr = data_addr; exp_wdata = data_wdata;
                        gold[data_addr[11:2]] = merge(gold[data_addr[11:2]], data_wdata, data_wstrb);
                    end
                    m_starve = (gd && inst_req) ? m_starve + 1 : 0;
                    m_gi = gi; m_gd = gd;
                end
            end
        end
    endtask

    task automatic mon_neg();
        logic gd, gi;
        forever begin
            @(negedge aclk);
            if (mon_en) begin
                gd = aresetn & data_req & (!inst_req | (m_starve < 4));
                gi = aresetn & inst_req & !gd;
                vectors += 4;
                if (data_ready !== gd) begin
                    miscompares++; $display("FAIL data_ready got %b exp %b t=%0t", data_ready, gd, $time);
                end
                if (inst_ready !== gi) begin
                    miscompares++; $display("FAIL inst_ready got %b exp %b t=%0t", inst_ready, gi, $time);
                end
                if (inst_rvalid !== exp_irv) begin
                    miscompares++; $display("FAIL inst_rvalid got %b exp %b t=%0t", inst_rvalid, exp_irv, $time);
                end
                if (data_rvalid !== exp_drv) begin
                    miscompares++; $display("FAIL data_rvalid got %b exp %b t=%0t", data_rvalid, exp_drv, $time);
                end
                if (exp_irv && iq.size() > 0) last_i = iq.pop_front();
                if (exp_drv && dq.size() > 0) last_d = dq.pop_front();
                vectors += 3;
                if (inst_rdata !== last_i) begin
                    miscompares++; $display("FAIL inst_rdata got %h exp %h t=%0t", inst_rdata, last_i, $time);
                end
                if (data_rdata !== last_d) begin
                    miscompares++; $display("FAIL data_rdata got %h exp %h t=%0t", data_rdata, last_d, $time);
                end
                if (ram_we !== exp_we) begin
                    miscompares++; $display("FAIL ram_we got %b exp %b t=%0t", ram_we, exp_we, $time);
                end
                if (gd || gi) begin
                    vectors++;
                    if (ram_raddr !== (gd ? data_addr : inst_addr)) begin
                        miscompares++;
                        $display("FAIL ram_raddr got %h exp %h t=%0t", ram_raddr, gd ? data_addr : inst_addr, $time);
                    end
                end
                if (exp_we) begin
                    vectors++;
                    if (ram_wsel !== exp_wsel || ram_waddr !== exp_waddr || ram_wdata !== exp_wdata) begin
                        miscompares++;
                        $display("FAIL ram_wcmd got %h/%h/%h exp %h/%h/%h t=%0t", ram_wsel, ram_waddr,
                                 ram_wdata, exp_wsel, exp_waddr, exp_wdata, $time);
                    end
                end
                vectors++;
                if (dut.r_starve_cnt > 4'd4) begin
                    miscompares++; $display("FAIL starve_bound got %0d exp <=4", dut.r_starve_cnt);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge aclk); #1;
        inst_req = 0; data_req = 0; data_wr = 0; data_wstrb = 4'd0;
        repeat (n - 1) @(posedge aclk);
    endtask

    task automatic test_reset();
        @(posedge aclk); #1;
        mon_en = 1;
        inst_req = 1; data_req = 1; data_wr = 0;
        @(negedge aclk);
        vectors++;
        if (inst_ready !== 1'b0 || data_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready got %b%b exp 00", inst_ready, data_ready);
        end
        @(posedge aclk); #1;
        inst_req = 0; data_req = 0;
        @(negedge aclk);
        vectors++;
        if ({inst_rvalid, data_rvalid, ram_we, ram_wsel, inst_rdata, data_rdata, ram_waddr, ram_wdata} !== '0) begin
            miscompares++; $display("FAIL reset_outputs got nonzero exp all 0");
        end
        @(posedge aclk); #1;
        aresetn = 1;
    endtask

    task automatic test_fetch_burst();
        for (int k = 0; k < 3; k++) begin
            @(posedge aclk); #1;
            inst_req = 1; inst_addr = 32'(4 * k);
            @(negedge aclk);
            vectors++;
            if (inst_ready !== 1'b1) begin
                miscompares++; $display("FAIL fetch_ready%0d got %b exp 1", k, inst_ready);
            end
        end
        @(posedge aclk); #1;
        inst_req = 0;
        @(negedge aclk);
        vectors++;
        if (inst_rvalid !== 1'b1 || inst_rdata !== pre_word(2)) begin
            miscompares++; $display("FAIL fetch_last got %b/%h exp 1/%h", inst_rvalid, inst_rdata, pre_word(2));
        end
        idle(2);
    endtask

    task automatic test_store_load();
        @(posedge aclk); #1;
        data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h10; data_wdata = 32'hDEADBEEF;
        @(posedge aclk); #1;
        data_wr = 0; data_wstrb = 4'h0;
        @(negedge aclk);
        vectors++;
        if (ram_we !== 1'b1) begin
            miscompares++; $display("FAIL store_we_on got %b exp 1", ram_we);
        end
        @(posedge aclk); #1;
        data_req = 0;
        @(negedge aclk);
        vectors++;
        if (ram_we !== 1'b0 || data_rdata !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL store_load got %b/%h exp 0/deadbeef", ram_we, data_rdata);
        end
        idle(2);
    endtask

    task automatic test_byte_strobe();
        @(posedge aclk); #1;
        data_req = 1; data_wr = 1; data_wstrb = 4'b0101; data_addr = 32'hFFFF_F020; data_wdata = 32'hAABBCCDD;
        @(posedge aclk); #1;
        data_wr = 0; data_wstrb = 4'h0; data_addr = 32'h20;
        @(posedge aclk); #1;
        data_req = 0;
        @(negedge aclk);
        vectors++;
        if (data_rvalid !== 1'b1 || data_rdata !== 32'h11BB33DD) begin
            miscompares++; $display("FAIL byte_merge got %b/%h exp 1/11bb33dd", data_rvalid, data_rdata);
        end
        idle(2);
    endtask

    task automatic test_starvation();
        @(posedge aclk); #1;
        inst_req = 1; inst_addr = 32'h4; data_req = 1; data_wr = 0; data_addr = 32'h8;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            vectors++;
            if (data_ready !== ((i % 5) != 4)) begin
                miscompares++; $display("FAIL starve_pattern%0d got %b exp %b", i, data_ready, (i % 5) != 4);
            end
            @(posedge aclk); #1;
        end
        inst_req = 0; data_req = 0;
        idle(2);
    endtask

    task automatic test_zero_strobe();
        @(posedge aclk); #1;
        data_req = 1; data_wr = 1; data_wstrb = 4'h0; data_addr = 32'h30; data_wdata = 32'h12345678;
        @(negedge aclk);
        vectors++;
        if (data_ready !== 1'b1) begin
            miscompares++; $display("FAIL zero_strb_ready got %b exp 1", data_ready);
        end
        @(posedge aclk); #1;
        data_wr = 0;
        @(negedge aclk);
        vectors++;
        if (ram_we !== 1'b0) begin
            miscompares++; $display("FAIL zero_strb_we got %b exp 0", ram_we);
        end
        @(posedge aclk); #1;
        data_req = 0;
        @(negedge aclk);
        vectors++;
        if (data_rdata !== pre_word(12)) begin
            miscompares++; $display("FAIL zero_strb_word got %h exp %h", data_rdata, pre_word(12));
        end
        idle(2);
    endtask

    task automatic test_reset_mid_store();
        @(posedge aclk); #1;
        data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h40; data_wdata = 32'hCAFEF00D;
        @(negedge aclk);
        vectors++;
        if (data_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_store_ready got %b exp 1", data_ready);
        end
        #1 aresetn = 0;
        #1;
        vectors++;
        if (data_ready !== 1'b0) begin
            miscompares++; $display("FAIL rst_forced_ready got %b exp 0", data_ready);
        end
        @(posedge aclk); #1;
        data_req = 0; data_wr = 0;
        @(negedge aclk);
        vectors++;
        if ({ram_we, inst_rvalid, data_rvalid, ram_wsel, inst_rdata, data_rdata, ram_waddr, ram_wdata} !== '0) begin
            miscompares++; $display("FAIL rst_mid_outputs got nonzero exp all 0");
        end
        @(posedge aclk); #1;
        aresetn = 1;
        data_req = 1; data_addr = 32'h40;
        @(posedge aclk); #1;
        data_req = 0;
        @(negedge aclk);
        vectors++;
        if (data_rdata !== pre_word(16)) begin
            miscompares++; $display("FAIL rst_mid_word got %h exp %h", data_rdata, pre_word(16));
        end
        idle(2);
    endtask

    task automatic test_random(input int n);
        logic [31:0] r;
        for (int c = 0; c < n; c++) begin
            @(posedge aclk); #1;
            if (!inst_req || m_gi) begin
                r = $urandom;
                inst_req = $urandom_range(0, 1) == 1;
                inst_addr = {r[31:12], 6'd0, r[5:2], r[1:0]};
            end
            if (!data_req || m_gd) begin
                r = $urandom;
                data_req = $urandom_range(0, 2) != 0;
                data_wr = r[6];
                data_wstrb = r[10:7];
                data_wdata = $urandom;
                data_addr = {r[31:12], 6'd0, r[5:2], r[1:0]};
            end
        end
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = pre_word(i);
            gold[i] = pre_word(i);
        end
        fork
            mon_pos();
            mon_neg();
        join_none
        test_reset();
        test_fetch_burst();
        test_store_load();
        test_byte_strobe();
        test_starvation();
        test_zero_strobe();
        test_reset_mid_store();
        test_random(300);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
